// File: rtl/pe_conv1d_ctrl.sv
// 1-D convolution window controller: fetches a FILT_SIZE-tap ifmap window per
// output (reusing overlapping taps when the stride is small), runs the PE, and
// hands each partial sum out over a valid/ready interface.
// pe_ifmap is packed as FILT_SIZE x 16-bit taps; each tap is a signed value.
module pe_conv1d_ctrl #(
    parameter int unsigned FILT_SIZE  = 5,
    parameter int unsigned PSUM_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                cmd_base_addr,
    input  logic [CNT_WIDTH-1:0]                 cmd_num_out,
    input  logic [3:0]                           cmd_stride,
    output logic                                 mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
    input  logic signed [15:0]                   mem_rd_data,
    output logic [FILT_SIZE-1:0][15:0]           pe_ifmap,
    output logic                                 pe_rstAccumulation,
    output logic                                 pe_start,
    input  logic                                 pe_done,
    input  logic signed [PSUM_WIDTH-1:0]         pe_psum,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [PSUM_WIDTH-1:0]         out_psum,
    output logic [CNT_WIDTH-1:0]                 out_index,
    output logic                                 out_last,
    output logic                                 busy
);

    localparam int unsigned TAP_W  = (FILT_SIZE > 1) ? $clog2(FILT_SIZE) : 1;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    state_t                          state, state_next;
    logic [ADDR_WIDTH-1:0]           ptr, ptr_next;
    logic [CNT_WIDTH-1:0]            k, k_next;
    logic [CNT_WIDTH-1:0]            num_q, num_next;
    logic [3:0]                      stride_q, stride_next;
    logic [TAP_W-1:0]                tap_q, tap_next;
    logic                            wr_en_q, wr_en_next;
    logic [TAP_W-1:0]                wr_tap_q, wr_tap_next;
    logic                            wide_stride;

    logic                            cmd_ready_next, busy_next;
    logic                            mem_rd_en_next;
    logic [ADDR_WIDTH-1:0]           mem_rd_addr_next;
    logic [FILT_SIZE-1:0][DATA_W-1:0] ifmap_next;
    logic                            pe_rst_acc_next, pe_start_next;
    logic                            out_valid_next, out_last_next;
    logic signed [PSUM_WIDTH-1:0]    out_psum_next;
    logic [CNT_WIDTH-1:0]            out_index_next;

    // A stride at least as wide as the window shares no taps with the previous one
    always_comb begin
        wide_stride = (32'(stride_q) >= FILT_SIZE);
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        k_next         = k;
        num_next       = num_q;
        stride_next    = stride_q;
        tap_next       = tap_q;
        ifmap_next     = pe_ifmap;
        out_psum_next  = out_psum;
        out_index_next = out_index;
        out_last_next  = out_last;
        wr_en_next     = (state == FETCH);
        wr_tap_next    = tap_q;

        // Read data returns one cycle after its request
        if (wr_en_q) begin
            ifmap_next[wr_tap_q] = mem_rd_data;
        end

        case (state)
            IDLE: begin
                if (cmd_valid && (cmd_num_out != '0)) begin
                    num_next    = cmd_num_out;
                    stride_next = (cmd_stride == 4'd0) ? 4'd1 : cmd_stride;
                    ptr_next    = cmd_base_addr;
                    k_next      = '0;
                    tap_next    = '0;
                    state_next  = FETCH;
                end
            end
            FETCH: begin
                // First cycle of a reuse fetch: slide the kept taps down
                if ((k != '0) && !wide_stride &&
                    (tap_q == TAP_W'(FILT_SIZE - 32'(stride_q)))) begin
                    for (int unsigned i = 0; i < FILT_SIZE; i++) begin
                        if (i + 32'(stride_q) < FILT_SIZE) begin
                            ifmap_next[TAP_W'(i)] = pe_ifmap[TAP_W'(i + 32'(stride_q))];
                        end
                    end
                end
                if (tap_q == TAP_W'(FILT_SIZE - 1)) begin
                    state_next = WAIT;
                end else begin
                    tap_next = tap_q + 1'b1;
                end
            end
            WAIT: begin
                state_next = CLEAR;
            end
            CLEAR: begin
                state_next = RUN;
            end
            RUN: begin
                if (pe_done) begin
                    out_psum_next  = pe_psum;
                    out_index_next = k;
                    out_last_next  = (k == CNT_WIDTH'(num_q - 1'b1));
                    state_next     = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_last_next = 1'b0;
                    if (out_last) begin
                        state_next = IDLE;
                    end else begin
                        k_next     = k + 1'b1;
                        ptr_next   = ptr + ADDR_WIDTH'(stride_q);
                        tap_next   = wide_stride ? '0 : TAP_W'(FILT_SIZE - 32'(stride_q));
                        state_next = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cmd_ready_next   = (state_next == IDLE);
        busy_next        = (state_next != IDLE);
        mem_rd_en_next   = (state_next == FETCH);
        mem_rd_addr_next = (state_next == FETCH) ? ADDR_WIDTH'(ptr_next + ADDR_WIDTH'(tap_next))
                                                 : mem_rd_addr;
        pe_rst_acc_next  = (state_next == CLEAR);
        pe_start_next    = (state_next == RUN);
        out_valid_next   = (state_next == DRAIN);
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            ptr                <= '0;
            k                  <= '0;
            num_q              <= '0;
            stride_q           <= 4'd1;
            tap_q              <= '0;
            wr_en_q            <= 1'b0;
            wr_tap_q           <= '0;
            cmd_ready          <= 1'b1;
            busy               <= 1'b0;
            mem_rd_en          <= 1'b0;
            mem_rd_addr        <= '0;
            pe_ifmap           <= '0;
            pe_rstAccumulation <= 1'b0;
            pe_start           <= 1'b0;
            out_valid          <= 1'b0;
            out_psum           <= '0;
            out_index          <= '0;
            out_last           <= 1'b0;
        end else begin
            state              <= state_next;
            ptr                <= ptr_next;
            k                  <= k_next;
            num_q              <= num_next;
            stride_q           <= stride_next;
            tap_q              <= tap_next;
            wr_en_q            <= wr_en_next;
            wr_tap_q           <= wr_tap_next;
            cmd_ready          <= cmd_ready_next;
            busy               <= busy_next;
            mem_rd_en          <= mem_rd_en_next;
            mem_rd_addr        <= mem_rd_addr_next;
            pe_ifmap           <= ifmap_next;
            pe_rstAccumulation <= pe_rst_acc_next;
            pe_start           <= pe_start_next;
            out_valid          <= out_valid_next;
            out_psum           <= out_psum_next;
            out_index          <= out_index_next;
            out_last           <= out_last_next;
        end
    end

endmodule
